sobel_grad_sink: RTL and testbench

//  Receiving end of the Sobel gradient AXI-Stream: accepts {dir[2:0], mag[11:0]} beats with tlast,

---
 rtl/sobel_pkg.sv | 38 +++
 rtl/sobel_grad_sink_skid.sv | 64 ++++++
 rtl/sobel_grad_sink.sv | 183 ++++++++++++++++++
 tb/tb_sobel_grad_sink.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_pkg
// Purpose  : Shared constants, field positions, FSM encoding and the magnitude
//            saturation helper for the Sobel gradient stream sink.
// Revision : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    // Default frame geometry; the sink recomputes its own total from its
    // IMG_WIDTH / IMG_HEIGHT parameters.
    localparam int DEF_IMG_WIDTH  = 128;
    localparam int DEF_IMG_HEIGHT = 128;
    localparam int TOTAL_PIXELS   = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

    // Stream beat layout: {dir[2:0], mag[11:0]}
    localparam int DIR_MSB = 14;
    localparam int DIR_LSB = 12;
    localparam int MAG_MSB = 11;

    // Result word layout: {dir[2:0], mag_sat[7:0]}
    localparam int WDATA_W = 11;

    localparam logic [7:0] MAG_SAT = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2
    } sink_state_t;

    // Clamp a 12-bit magnitude into 8 bits.
    function automatic logic [7:0] sat_mag(input logic [MAG_MSB:0] mag);
        return (mag > 12'd255) ? MAG_SAT : mag[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_grad_sink_skid.sv
`default_nettype none
// ============================================================================
// Module   : stream_skid_buffer
// Purpose  : Two-entry valid/ready buffer. Accepts one word per cycle while
//            not full and presents the oldest word on the output; output data
//            is held stable until consumed.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/ready  - upstream handshake, in_data payload
//            out_valid/ready - downstream handshake, out_data payload
// Revision : 1.0 - initial release
// ============================================================================
module stream_skid_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] r_slot [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    // Ready depends only on registered occupancy, so a word pushed this cycle
    // is visible on the output next cycle and a full buffer stalls upstream.
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_slot[r_rptr];
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_slot[r_wptr] <= in_data;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_grad_sink.sv
`default_nettype none
// ============================================================================
// Module   : sobel_grad_sink
// Purpose  : Receives {dir, mag} Sobel beats, checks frame length against
//            IMG_WIDTH*IMG_HEIGHT, saturates magnitude to 8 bits and writes
//            {dir, mag_sat} into a raster-ordered memory through a stallable
//            write port. Reports frame completion and framing errors.
// Ports    : clk, rst                    - clock, synchronous active-high reset
//            start                       - arm one frame (ignored while busy)
//            s_axis_tdata/tvalid/tready/tlast - input stream
//            mem_we/addr/wdata, mem_ready - result memory write port
//            busy, frame_done            - frame status
//            err_early_last, err_missing_last - sticky framing errors
//            hist_sel, hist_count        - per-direction write histogram
// Config   : SOBEL_SINK_HIST_EN - enables the 8-bin direction histogram;
//            when undefined hist_count reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_grad_sink
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 128,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [14:0]           s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [10:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_early_last,
    output logic                  err_missing_last,
    input  logic [2:0]            hist_sel,
    output logic [ADDR_WIDTH:0]   hist_count
);

    localparam int                    TOTAL    = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TOTAL - 1);
    // Skid entry: {final, addr, dir, mag_sat}
    localparam int                    ENTRY_W  = 1 + ADDR_WIDTH + WDATA_W;

    sink_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_err_early;
    logic                  r_err_missing;

    logic                  w_skid_in_ready;
    logic                  w_out_valid;
    logic [ENTRY_W-1:0]    w_out_data;
    logic [ENTRY_W-1:0]    w_in_data;
    logic                  w_accept;
    logic                  w_at_last;
    logic                  w_final;
    logic                  w_write;
    logic                  w_out_final;
    logic                  w_start_ok;

    assign s_axis_tready = (r_state == ST_RECV) && w_skid_in_ready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_at_last     = (r_idx == LAST_IDX);
    // The frame ends at whichever comes first: tlast or the last raster index.
    assign w_final       = s_axis_tlast || w_at_last;
    assign w_in_data     = {w_final, r_idx, s_axis_tdata[DIR_MSB:DIR_LSB],
                            sat_mag(s_axis_tdata[MAG_MSB:0])};

    // A start coinciding with the frame_done pulse is dropped even though
    // the FSM is already back in IDLE.
    assign w_start_ok    = (r_state == ST_IDLE) && start && !r_frame_done;

    stream_skid_buffer #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_axis_tvalid && (r_state == ST_RECV)),
        .in_ready  (w_skid_in_ready),
        .in_data   (w_in_data),
        .out_valid (w_out_valid),
        .out_ready (mem_ready),
        .out_data  (w_out_data)
    );

    assign mem_we      = w_out_valid;
    assign mem_addr    = w_out_data[ENTRY_W-2:WDATA_W];
    assign mem_wdata   = w_out_data[WDATA_W-1:0];
    assign w_out_final = w_out_data[ENTRY_W-1];
    assign w_write     = mem_we && mem_ready;

    assign busy             = r_busy;
    assign frame_done       = r_frame_done;
    assign err_early_last   = r_err_early;
    assign err_missing_last = r_err_missing;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state       <= ST_RECV;
                        r_busy        <= 1'b1;
                        r_idx         <= '0;
                        r_err_early   <= 1'b0;
                        r_err_missing <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (w_accept) begin
                        if (s_axis_tlast && !w_at_last) begin
                            r_err_early <= 1'b1;
                        end
                        if (w_at_last && !s_axis_tlast) begin
                            r_err_missing <= 1'b1;
                        end
                        if (w_final) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The final entry is the last one in the buffer, so its
                    // write handshake also means the buffer is now empty.
                    if (w_write && w_out_final) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SOBEL_SINK_HIST_EN
    logic [ADDR_WIDTH:0] r_hist [8];
    logic [ADDR_WIDTH:0] r_hist_count;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            for (int b = 0; b < 8; b++) begin
                r_hist[b] <= '0;
            end
        end else if (w_write) begin
            r_hist[mem_wdata[10:8]] <= r_hist[mem_wdata[10:8]] + 1'b1;
        end
        if (rst) begin
            r_hist_count <= '0;
        end else begin
            r_hist_count <= r_hist[hist_sel];
        end
    end

    assign hist_count = r_hist_count;
`else
    logic w_unused_hist_sel;

    assign w_unused_hist_sel = ^hist_sel;
    assign hist_count        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobel_grad_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_grad_sink
// Purpose  : Self-checking bench for sobel_grad_sink on a 4x4 frame. A
//            reference model turns every accepted beat into the expected
//            {addr, dir, mag_sat} write and predicts framing flags, done
//            pulses and the per-direction histogram.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_grad_sink;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int AW    = 4;
    localparam int TOTAL = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [14:0]   tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [10:0]   mem_wdata;
    logic          mem_ready;
    logic          busy;
    logic          frame_done;
    logic          err_e;
    logic          err_m;
    logic [2:0]    hist_sel;
    logic [AW:0]   hist_count;

    sobel_grad_sink #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .s_axis_tdata     (tdata),
        .s_axis_tvalid    (tvalid),
        .s_axis_tready    (tready),
        .s_axis_tlast     (tlast),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ready        (mem_ready),
        .busy             (busy),
        .frame_done       (frame_done),
        .err_early_last   (err_e),
        .err_missing_last (err_m),
        .hist_sel         (hist_sel),
        .hist_count       (hist_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [AW+10:0] exp_q [$];      // expected {addr, dir, mag_sat} in order
    int             mdl_idx;
    int             mdl_total;
    int             n_writes;
    int             hist_mdl [8];
    bit             exp_done;
    bit             lat_pend;
    bit             stall_pend;
    logic [AW+10:0] stall_val;
    bit             in_frame;
    bit             saw_stall;
    int             rdy_mode = 0;
    int             cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [14:0] make_beat(input int i, input int dmode);
        logic [11:0] m;
        logic [2:0]  d;
        m = 12'($urandom);
        d = 3'($urandom);
        case (dmode)
            0: begin
                m = 12'(i * 61);      // ramp that crosses 255 at beat 5
                d = 3'(i);
            end
            2: d = 3'd3;
            default: begin
                case ($urandom_range(0, 3))
                    0:       m = 12'd255;
                    1:       m = 12'd256;
                    2:       m = 12'($urandom_range(0, 255));
                    default: ;
                endcase
                if (i == 0) begin
                    m = 12'h3E8;
                    d = 3'd5;
                end
                if (i == 1) m = 12'h0C8;
            end
        endcase
        return {d, m};
    endfunction

    // Negedge observer: scoreboard of memory writes, latency, hold-while-
    // stalled, and exact frame_done timing.
    task automatic monitor();
        logic [AW+10:0] e;
        logic [7:0]     sat;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_done   = 0;
                lat_pend   = 0;
                stall_pend = 0;
            end else begin
                check_val("frame_done", frame_done, exp_done);
                exp_done = 0;
                if (lat_pend) check_val("latency_we", mem_we, 1);
                lat_pend = 0;
                if (stall_pend) check_val("stall_hold", {mem_we, mem_addr, mem_wdata}, {1'b1, stall_val});
                stall_pend = 0;
                if (in_frame && !tready) saw_stall = 1;
                if (tvalid && tready) begin
                    sat = (tdata[11:0] > 12'd255) ? 8'hFF : tdata[7:0];
                    exp_q.push_back({mdl_idx[AW-1:0], tdata[14:12], sat});
                    mdl_idx++;
                    lat_pend = 1;
                end
                if (mem_we && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("spurious_write", mem_we, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("write", {mem_addr, mem_wdata}, e);
                        hist_mdl[e[10:8]]++;
                        n_writes++;
                        if (n_writes == mdl_total) exp_done = 1;
                    end
                end else if (mem_we) begin
                    stall_pend = 1;
                    stall_val  = {mem_addr, mem_wdata};
                end
            end
        end
    endtask

    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = (cyc % 3 == 0);
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_beat(input int i, input int tl, input int dmode);
        bit ok;
        int guard;
        tvalid = 1'b1;
        tdata  = make_beat(i, dmode);
        tlast  = (i == tl);
        ok     = 0;
        guard  = 0;
        while (!ok && guard < 60) begin
            @(negedge clk);
            ok = tready;
            guard++;
            @(posedge clk);
            #1;
        end
        if (!ok) check_val("beat_timeout", ok, 1);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic begin_frame(input int total, input int rmode);
        mdl_idx   = 0;
        mdl_total = total;
        n_writes  = 0;
        for (int b = 0; b < 8; b++) hist_mdl[b] = 0;
        saw_stall = 0;
        rdy_mode  = rmode;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        in_frame  = 1;
        check_val("busy_after_start", busy, 1);
        check_val("errs_cleared", {err_e, err_m}, 0);
    endtask

    // tlast_at < 0 or beyond the frame means no tlast is ever sent.
    task automatic run_frame(input int tlast_at, input int rmode, input int dmode,
                             input bit probe_extra, input bit start_on_done);
        int n_acc;
        bit exp_early;
        bit exp_miss;
        bit got_done;
        int guard;
        exp_early = (tlast_at >= 0) && (tlast_at < TOTAL - 1);
        exp_miss  = (tlast_at != TOTAL - 1) && !exp_early;
        n_acc     = exp_early ? tlast_at + 1 : TOTAL;
        begin_frame(n_acc, rmode);
        for (int i = 0; i < n_acc; i++) send_beat(i, tlast_at, dmode);
        in_frame = 0;
        if (rmode == 0) check_val("tready_never_low", saw_stall, 0);
        if (rmode == 1) check_val("tready_dropped", saw_stall, 1);
        if (probe_extra) begin
            tvalid = 1'b1;
            tdata  = 15'($urandom);
            tlast  = 1'b1;
        end
        got_done = 0;
        guard    = 0;
        while (!got_done && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
            if (probe_extra) check_val("extra_beat_tready", tready, 0);
            if (frame_done) begin
                got_done = 1;
                if (start_on_done) start = 1'b1;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        check_val("frame_done_seen", got_done, 1);
        check_val("busy_low_at_done", busy, 0);
        if (start_on_done) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            check_val("start_on_done_ignored", busy, 0);
        end
        check_val("err_early_last", err_e, exp_early);
        check_val("err_missing_last", err_m, exp_miss);
        check_val("write_count", n_writes, n_acc);
`ifdef SOBEL_SINK_HIST_EN
        for (int b = 0; b < 8; b++) begin
            hist_sel = b[2:0];
            @(posedge clk);
            @(posedge clk);
            #1;
            check_val("hist_count", hist_count, hist_mdl[b]);
        end
`else
        hist_sel = 3'($urandom);
        @(posedge clk);
        #1;
        check_val("hist_count_tied", hist_count, 0);
`endif
    endtask

    task automatic reset_mid_frame();
        begin_frame(1000, 1);
        for (int i = 0; i < 8; i++) send_beat(i, -1, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        in_frame = 0;
        check_val("reset_abort_outputs",
                  {tready, mem_we, mem_addr, mem_wdata, busy, frame_done, err_e, err_m, hist_count}, 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_val("reset_abort_idle", {busy, mem_we}, 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        tvalid   = 1'b0;
        tlast    = 1'b0;
        tdata    = '0;
        hist_sel = 3'd0;
        in_frame = 0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs",
                  {tready, mem_we, mem_addr, mem_wdata, busy, frame_done, err_e, err_m, hist_count}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Beats offered in IDLE must not be taken.
        tvalid = 1'b1;
        tdata  = 15'($urandom);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_val("idle_tready", tready, 0);
        end
        tvalid = 1'b0;

        run_frame(15, 0, 0, 0, 1);   // clean ramp frame, start during done ignored
        run_frame(15, 1, 1, 0, 0);   // saturation values, memory stalls 2-of-3
        run_frame(9,  0, 1, 0, 0);   // early tlast
        run_frame(15, 0, 1, 0, 0);   // clean frame clears the flag
        run_frame(-1, 0, 1, 1, 0);   // missing tlast, 17th beat refused
        reset_mid_frame();
        run_frame(15, 2, 2, 0, 0);   // all directions 3
        repeat (4) begin
            int tl;
            tl = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TOTAL - 1));
            run_frame(tl, int'($urandom_range(0, 2)), 1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
